// File: rtl/interleaver_ctrl.sv
// interleaver_ctrl
//   Address and sequencing controller for a ROWS x COLS block interleaver that
//   sits on a two-bank (ping-pong) synchronous RAM. Incoming symbols are
//   written row-major into the write bank. Each completed bank is then read
//   column-major while the next frame fills the other bank.
//
// Reader FSM states
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | no complete frame pending, rd_en low
//   ST_READ | emitting one column-major read address per cycle from rbank
//
// Ports
//   clk2        single clock, rising edge
//   rst_n       synchronous active-low reset
//   din_valid   one input symbol accepted this cycle
//   flush       discard the partial write frame; also suppresses the write
//   wr_en       RAM write strobe (combinational)
//   wr_addr     {wbank, w_idx}
//   rd_en       RAM read strobe (registered)
//   rd_addr     {rbank, r*COLS+c} (registered)
//   dout_valid  rd_en delayed by the one-cycle RAM read latency
//   frame_done  pulse on the last read of a frame
//   busy        a partial frame is held or a read is in progress
module interleaver_ctrl #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk2,
    input  logic              rst_n,
    input  logic              din_valid,
    input  logic              flush,
    output logic              wr_en,
    output logic [ADDR_W:0]   wr_addr,
    output logic              rd_en,
    output logic [ADDR_W:0]   rd_addr,
    output logic              dout_valid,
    output logic              frame_done,
    output logic              busy
);

    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
    localparam logic [RW-1:0]     R_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0]     C_LAST = CW'(COLS - 1);

    typedef enum logic {
        ST_IDLE,
        ST_READ
    } rd_state_t;

    rd_state_t         state_q, state_d;
    logic [ADDR_W-1:0] w_idx_q, w_idx_d;
    logic              wbank_q, wbank_d;
    logic              rbank_q, rbank_d;
    logic [RW-1:0]     r_q, r_d;
    logic [CW-1:0]     c_q, c_d;
    logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
    logic              rd_en_q, rd_en_d;
    logic              frame_done_q, frame_done_d;
    logic              dout_valid_q, dout_valid_d;
    logic              frame_full;
    logic              last_rd;

    // Writer. flush wins over din_valid, so a flushed final symbol never
    // completes a frame.
    always_comb begin
        wr_en      = rst_n & din_valid & ~flush;
        frame_full = wr_en && (w_idx_q == W_LAST);
        w_idx_d    = w_idx_q;
        wbank_d    = wbank_q;
        if (flush) begin
            w_idx_d = '0;
        end else if (wr_en) begin
            if (w_idx_q == W_LAST) begin
                w_idx_d = '0;
                wbank_d = ~wbank_q;
            end else begin
                w_idx_d = w_idx_q + ADDR_W'(1);
            end
        end
    end

    // Reader. All read-side outputs are computed from the next-state values
    // and registered, so they appear the cycle after the decision.
    always_comb begin
        state_d = state_q;
        rbank_d = rbank_q;
        r_d     = r_q;
        c_d     = c_q;
        last_rd = (r_q == R_LAST) && (c_q == C_LAST);
        case (state_q)
            ST_IDLE: begin
                if (frame_full) begin
                    state_d = ST_READ;
                    rbank_d = wbank_q;
                    r_d     = '0;
                    c_d     = '0;
                end
            end
            ST_READ: begin
                if (last_rd) begin
                    r_d = '0;
                    c_d = '0;
                    if (frame_full) begin
                        // back-to-back frame: keep reading with no gap
                        rbank_d = wbank_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (r_q == R_LAST) begin
                    r_d = '0;
                    c_d = c_q + CW'(1);
                end else begin
                    r_d = r_q + RW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        rd_en_d      = (state_d == ST_READ);
        rd_idx_d     = ADDR_W'(r_d) * COLS_A + ADDR_W'(c_d);
        frame_done_d = (state_d == ST_READ) && (r_d == R_LAST) && (c_d == C_LAST);
        dout_valid_d = rd_en_q;
    end

    always_ff @(posedge clk2) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            w_idx_q      <= '0;
            wbank_q      <= 1'b0;
            rbank_q      <= 1'b0;
            r_q          <= '0;
            c_q          <= '0;
            rd_idx_q     <= '0;
            rd_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            w_idx_q      <= w_idx_d;
            wbank_q      <= wbank_d;
            rbank_q      <= rbank_d;
            r_q          <= r_d;
            c_q          <= c_d;
            rd_idx_q     <= rd_idx_d;
            rd_en_q      <= rd_en_d;
            frame_done_q <= frame_done_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign wr_addr    = {wbank_q, w_idx_q};
    assign rd_en      = rd_en_q;
    assign rd_addr    = {rbank_q, rd_idx_q};
    assign frame_done = frame_done_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (w_idx_q != '0) || (state_q == ST_READ);

endmodule
